// File: rtl/av_ser_pkg.sv
// Shared types and width helpers for the vector serializer slice.
package av_ser_pkg;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} ser_state_e;

  // Index width: max(1, clog2(n)).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int total_w(input int rows, input int cols, input int elem_w);
    return rows * cols * elem_w;
  endfunction

endpackage

// File: rtl/av_vector_serializer_if.sv
// Requester / core-method / element-stream bundle seen by the serializer.
interface av_ser_if #(
  parameter int ROWS   = 3,
  parameter int COLS   = 4,
  parameter int ELEM_W = 18,
  parameter int ARG_W  = 32
);
  import av_ser_pkg::*;
  localparam int TOTAL = total_w(ROWS, COLS, ELEM_W);
  localparam int RW    = idx_w(ROWS);
  localparam int CW    = idx_w(COLS);

  logic              req_valid;
  logic              req_ready;
  logic [ARG_W-1:0]  req_arg;
  logic              RDY_method;
  logic              EN_method;
  logic [ARG_W-1:0]  method_in1;
  logic [TOTAL-1:0]  method_result;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_elem;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic              out_last;
  logic              flush;

  modport slave (
    input  req_valid, req_arg, RDY_method, method_result, out_ready, flush,
    output req_ready, EN_method, method_in1, out_valid, out_elem, out_row, out_col, out_last
  );

  modport master (
    output req_valid, req_arg, RDY_method, method_result, out_ready, flush,
    input  req_ready, EN_method, method_in1, out_valid, out_elem, out_row, out_col, out_last
  );

endinterface

// File: rtl/av_vector_serializer_elem_sel.sv
// Combinational (row,col) -> element slice mux; element (0,0) sits at the buffer MSBs.
module av_vector_elem_sel
  import av_ser_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 4,
  parameter int ELEM_W = 18
) (
  input  logic [ROWS*COLS*ELEM_W-1:0] i_buf,
  input  logic [idx_w(ROWS)-1:0]      i_row,
  input  logic [idx_w(COLS)-1:0]      i_col,
  output logic [ELEM_W-1:0]           o_elem
);
  localparam int N     = ROWS * COLS;
  localparam int TOTAL = total_w(ROWS, COLS, ELEM_W);

  logic [N-1:0][ELEM_W-1:0] w_elems;

  for (genvar k = 0; k < N; k++) begin : g_unpk
    assign w_elems[k] = i_buf[TOTAL-1-k*ELEM_W -: ELEM_W];
  end

  always_comb begin
    o_elem = '0;
    for (int k = 0; k < N; k++)
      if (int'(i_row) * COLS + int'(i_col) == k) o_elem = w_elems[k];
  end

endmodule

// File: rtl/av_vector_serializer.sv
// Fires the core method once per request, buffers the packed Vector result and streams it out element by element.
module av_vector_serializer
  import av_ser_pkg::*;
#(
  parameter int ROWS      = 3,
  parameter int COLS      = 4,
  parameter int ELEM_W    = 18,
  parameter int ARG_W     = 32,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic   CLK,
  input  logic   RST_N,
  av_ser_if.slave bus
);
  localparam int TOTAL = total_w(ROWS, COLS, ELEM_W);
  localparam int RW    = idx_w(ROWS);
  localparam int CW    = idx_w(COLS);
  localparam logic [0:0]    S_IDLE  = ST_IDLE;
  localparam logic [0:0]    S_DRAIN = ST_DRAIN;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [0:0]        r_state;
  logic [TOTAL-1:0]  r_buf;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;

  logic              w_valid, w_last, w_hs, w_ready, w_en;
  logic              w_row_wrap, w_col_wrap;
  logic [ELEM_W-1:0] w_elem;

  assign w_row_wrap = (r_row == ROW_MAX);
  assign w_col_wrap = (r_col == COL_MAX);
  assign w_valid    = (r_state == S_DRAIN);
  assign w_last     = w_valid && w_row_wrap && w_col_wrap;
  assign w_hs       = w_valid && bus.out_ready;
  // A new request may overlap the last handshake so results stream without a bubble.
  assign w_ready    = bus.RDY_method && !bus.flush && ((r_state == S_IDLE) || (w_hs && w_last));
  assign w_en       = bus.req_valid && w_ready;

  assign bus.req_ready  = w_ready;
  assign bus.EN_method  = w_en;
  assign bus.method_in1 = bus.req_arg;
  assign bus.out_valid  = w_valid;
  assign bus.out_last   = w_last;
  assign bus.out_row    = r_row;
  assign bus.out_col    = r_col;
  assign bus.out_elem   = w_elem;

  av_vector_elem_sel #(.ROWS(ROWS), .COLS(COLS), .ELEM_W(ELEM_W)) u_sel (
    .i_buf  (r_buf),
    .i_row  (r_row),
    .i_col  (r_col),
    .o_elem (w_elem)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_en) begin
      r_state <= S_DRAIN;
      r_buf   <= bus.method_result;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_hs) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_row   <= '0;
        r_col   <= '0;
      end else if (!COL_MAJOR) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        if (w_row_wrap) begin
          r_row <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

endmodule
